// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the strobe-interface FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Largest legal storage depth exponent accepted by the FIFOs
    localparam int FIFO_MAX_DEPTH_LOG2 = 12;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Simple dual-port storage array for sync_stb_fifo. One
//               synchronous write port; the read port is asynchronous when
//               SYNC_FIFO_FWFT_EN is defined, registered otherwise.
// Macros      : SYNC_FIFO_FWFT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused_re;
    assign w_unused_re = i_re;

    // Fall-through read: head word shown directly, forced to zero in reset
    assign o_rdata = rst ? '0 : mem_q[i_raddr];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read: capture the addressed word only on an accepted pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;
`endif

endmodule : sync_fifo_ram
`default_nettype wire

// File: rtl/sync_stb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_stb_fifo
// Description : Single-clock strobe-interface FIFO. Write/read strobes are
//               qualified by the registered not_full/not_empty flags, so
//               consumer back-pressure propagates upstream via not_full.
// Macros      : SYNC_FIFO_FWFT_EN (first-word fall-through read port)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_stb_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_w_stb,
    output logic                  o_fifo_not_full,
    input  logic                  i_fifo_r_stb,
    output logic                  o_fifo_not_empty,
    output logic [DATA_WIDTH-1:0] o_fifo_data,
    output logic                  o_fifo_r_valid,
    output logic [DEPTH_LOG2:0]   o_fifo_count
);

    localparam int PTR_W = ptr_w(DEPTH_LOG2);

    generate
        if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 > FIFO_MAX_DEPTH_LOG2)) begin : g_bad_depth
            $error("sync_stb_fifo: DEPTH_LOG2 out of range 1..%0d", FIFO_MAX_DEPTH_LOG2);
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Flags come straight from the registered pointers; full means same slot
    // on opposite laps, so a same-cycle read cannot make room for a write
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign w_wr_acc = i_fifo_w_stb & ~w_full;
    assign w_rd_acc = i_fifo_r_stb & ~w_empty;

    // Next pointer values: advance on accepted strobes, wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, w_wr_acc};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, w_rd_acc};
    end

    // Pointer registers; reset discards all stored words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign o_fifo_not_full  = ~w_full;
    assign o_fifo_not_empty = ~w_empty;
    assign o_fifo_count     = wr_ptr_q - rd_ptr_q;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (wr_ptr_q[PTR_W-2:0]),
        .i_wdata (i_fifo_data),
        .i_re    (w_rd_acc),
        .i_raddr (rd_ptr_q[PTR_W-2:0]),
        .o_rdata (o_fifo_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign o_fifo_r_valid = ~w_empty;
`else
    logic rd_valid_q;

    // One-cycle valid pulse following each accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_rd_acc;
        end
    end

    assign o_fifo_r_valid = rd_valid_q;
`endif

endmodule : sync_stb_fifo
`default_nettype wire

// File: tb/tb_sync_stb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_stb_fifo
// Description : Directed self-checking bench for sync_stb_fifo (4-deep,
//               8-bit words). Follows SYNC_FIFO_FWFT_EN for read timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_stb_fifo;

    localparam int DW = 8;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_fifo_data;
    logic          i_fifo_w_stb;
    logic          i_fifo_r_stb;
    logic          o_fifo_not_full;
    logic          o_fifo_not_empty;
    logic [DW-1:0] o_fifo_data;
    logic          o_fifo_r_valid;
    logic [DL:0]   o_fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    sync_stb_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_fifo_data      (i_fifo_data),
        .i_fifo_w_stb     (i_fifo_w_stb),
        .o_fifo_not_full  (o_fifo_not_full),
        .i_fifo_r_stb     (i_fifo_r_stb),
        .o_fifo_not_empty (o_fifo_not_empty),
        .o_fifo_data      (o_fifo_data),
        .o_fifo_r_valid   (o_fifo_r_valid),
        .o_fifo_count     (o_fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        i_fifo_w_stb = w;
        i_fifo_data  = d;
        i_fifo_r_stb = r;
        @(posedge clk);
        #1;
        i_fifo_w_stb = 1'b0;
        i_fifo_r_stb = 1'b0;
    endtask

    task automatic flags(input string tag, input int cnt, input logic nf, input logic ne);
        chk({tag, "_count"},    32'(o_fifo_count),     32'(cnt));
        chk({tag, "_not_full"}, 32'(o_fifo_not_full),  32'(nf));
        chk({tag, "_not_empty"},32'(o_fifo_not_empty), 32'(ne));
    endtask

    // Pop one word, optionally with a simultaneous write, checking the head
    task automatic pop(input string tag, input logic [DW-1:0] exp, input logic w, input logic [DW-1:0] wd);
`ifdef SYNC_FIFO_FWFT_EN
        chk({tag, "_valid"}, 32'(o_fifo_r_valid), 32'd1);
        chk({tag, "_data"},  32'(o_fifo_data),    32'(exp));
        step(w, wd, 1'b1);
`else
        step(w, wd, 1'b1);
        chk({tag, "_valid"}, 32'(o_fifo_r_valid), 32'd1);
        chk({tag, "_data"},  32'(o_fifo_data),    32'(exp));
`endif
    endtask

    initial begin
        rst          = 1'b1;
        i_fifo_data  = 8'hFF;
        i_fifo_w_stb = 1'b1;
        i_fifo_r_stb = 1'b1;

        // Reset: strobes held high must be ignored
        @(posedge clk);
        @(posedge clk);
        #1;
        flags("rst", 0, 1'b1, 1'b0);
        chk("rst_valid", 32'(o_fifo_r_valid), 32'd0);
        chk("rst_data",  32'(o_fifo_data),    32'd0);
        rst          = 1'b0;
        i_fifo_w_stb = 1'b0;
        i_fifo_r_stb = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        flags("post_rst", 0, 1'b1, 1'b0);

        // Fill to full, then an extra write is dropped
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b0);
            chk("fill_count", 32'(o_fifo_count), 32'(i + 1));
        end
        flags("full", 4, 1'b0, 1'b1);
        step(1'b1, 8'hA4, 1'b0);
        flags("overfill", 4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pop("drain", 8'hA0 + 8'(i), 1'b0, 8'h00);
            if (i == 0) chk("not_full_after_pop", 32'(o_fifo_not_full), 32'd1);
        end
        flags("drained", 0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("idle_valid", 32'(o_fifo_r_valid), 32'd0);

        // Pointer wrap: ten write/read pairs
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
            chk("wrap_count", 32'(o_fifo_count), 32'd1);
            pop("wrap", 8'h10 + 8'(i), 1'b0, 8'h00);
        end
        flags("wrap_end", 0, 1'b1, 1'b0);

        // Simultaneous strobes at full: read wins, write dropped
        for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
        pop("both_full", 8'hB0, 1'b1, 8'hEE);
        flags("both_full", 3, 1'b1, 1'b1);
        pop("after_full1", 8'hB1, 1'b0, 8'h00);
        pop("after_full2", 8'hB2, 1'b0, 8'h00);
        pop("after_full3", 8'hB3, 1'b0, 8'h00);
        flags("after_full", 0, 1'b1, 1'b0);

        // Simultaneous strobes at empty: write wins, read ignored
        step(1'b1, 8'h55, 1'b1);
        flags("both_empty", 1, 1'b1, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("both_empty_valid", 32'(o_fifo_r_valid), 32'd0);
`endif
        pop("empty_word", 8'h55, 1'b0, 8'h00);

        // Simultaneous strobes mid-level: count unchanged
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        pop("both_mid", 8'h01, 1'b1, 8'h03);
        chk("both_mid_count", 32'(o_fifo_count), 32'd2);
        pop("mid2", 8'h02, 1'b0, 8'h00);
        pop("mid3", 8'h03, 1'b0, 8'h00);

        // Read timing
        step(1'b1, 8'h11, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_valid", 32'(o_fifo_r_valid), 32'd1);
        chk("fwft_data",  32'(o_fifo_data),    32'h11);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_valid_gone", 32'(o_fifo_r_valid), 32'd0);
`else
        chk("std_no_valid", 32'(o_fifo_r_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("std_valid", 32'(o_fifo_r_valid), 32'd1);
        chk("std_data",  32'(o_fifo_data),    32'h11);
        step(1'b0, 8'h00, 1'b0);
        chk("std_pulse_end", 32'(o_fifo_r_valid), 32'd0);
        chk("std_data_hold", 32'(o_fifo_data),    32'h11);
`endif

        // Asynchronous reset between edges with three words stored
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h23, 1'b0);
        chk("pre_arst_count", 32'(o_fifo_count), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        flags("arst", 0, 1'b1, 1'b0);
        chk("arst_valid", 32'(o_fifo_r_valid), 32'd0);
        chk("arst_data",  32'(o_fifo_data),    32'd0);
        #1;
        rst = 1'b0;
        step(1'b1, 8'h77, 1'b0);
        chk("post_arst_count", 32'(o_fifo_count), 32'd1);
        pop("post_arst", 8'h77, 1'b0, 8'h00);
        flags("final", 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sync_stb_fifo
`default_nettype wire
